// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and helpers for the serial-to-parallel frame controller.
// The PARITY state is only reachable when SIPO_FRAME_CTRL_PARITY_EN is defined.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Bit-counter width that can hold the values 0..width.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Plain WIDTH-bit shift-left register with serial input; the first bit shifted
// in ends up in the MSB after WIDTH shifts. Synchronous active-low reset.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // NOTE: the data register is cleared on reset even though a full frame
  // overwrites it, so an aborted frame never leaves visible bits behind.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {r_q[WIDTH-2:0], d};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Serial-to-parallel frame controller with valid/ready output and sticky overrun.
// Define SIPO_FRAME_CTRL_PARITY_EN to add a trailing even-parity bit per frame.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             d,
  input  logic             ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_sr_q;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_shift_en;
  logic             w_complete;
  logic             w_last_bit;
  logic             w_load;
  logic             w_drop;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clock    (clock),
    .reset    (reset),
    .shift_en (w_shift_en),
    .d        (d),
    .q        (w_sr_q)
  );

  assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        w_shift_en = 1'b1;
        if (w_last_bit) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
          w_next_state = PARITY;
`else
          w_next_state = IDLE;
          w_complete   = 1'b1;
`endif
        end
      end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
      PARITY: begin
        w_next_state = IDLE;
        w_complete   = 1'b1;
      end
`endif
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (r_state == IDLE) begin
      r_count <= '0;
    end else if (w_shift_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Without parity the last data bit is still on d at the completion edge.
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  assign w_word = w_sr_q;
`else
  assign w_word = {w_sr_q[WIDTH-2:0], d};
`endif

  assign w_load = w_complete && (!r_valid || ready);
  assign w_drop = w_complete && r_valid && !ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= (^w_word) ^ d;
    end
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_msb;
  assign w_unused_msb = w_sr_q[WIDTH-1];
  assign parity_err   = 1'b0;
`endif

  assign data_out = r_data;
  assign valid    = r_valid;
  assign overrun  = r_overrun;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl (WIDTH=4): directed scenarios plus
// randomized frames against a transaction-level reference model.
module tb_sipo_frame_ctrl;

  localparam int W = 4;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         start   = 1'b0;
  logic         d       = 1'b0;
  logic         ready   = 1'b0;
  logic         clr_ovr = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the consumer should see.
  logic [W-1:0] m_data  = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_perr  = 1'b0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .d          (d),
    .ready      (ready),
    .clr_ovr    (clr_ovr),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  // One clock edge with the given inputs; the model is told whether this edge
  // completes a frame carrying 'word' (and parity bit 'pbit').
  task automatic tick(input logic s, input logic dd, input logic rdy, input logic clr,
                      input bit completes, input logic [W-1:0] word, input logic pbit);
    start   = s;
    d       = dd;
    ready   = rdy;
    clr_ovr = clr;
    @(posedge clock);
    if (!reset) begin
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else if (completes) begin
      if (m_valid && !rdy) begin
        m_ovr = 1'b1;
      end else begin
        m_data  = word;
        m_valid = 1'b1;
        if (PAR) m_perr = (^word) ^ pbit;
        if (clr) m_ovr = 1'b0;
      end
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (clr) m_ovr = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input logic rdy, input logic clr);
    tick(1'b0, 1'($urandom), rdy, clr, 1'b0, '0, 1'b0);
  endtask

  // Full frame: start cycle, W data bits MSB first, optional parity bit.
  // ready is rdy_body except on the completion edge, where it is rdy_last.
  task automatic run_frame(input logic [W-1:0] word, input logic pbit, input logic rdy_body,
                           input logic rdy_last, input logic clr, input logic [W-1:0] start_mask);
    tick(1'b1, 1'($urandom), rdy_body, clr, 1'b0, '0, 1'b0);
    for (int i = 0; i < W; i++) begin
      bit last;
      last = (i == W - 1) && !PAR;
      tick(start_mask[i], word[W-1-i], last ? rdy_last : rdy_body, clr, last, word, pbit);
    end
    if (PAR) tick(1'b0, pbit, rdy_last, clr, 1'b1, word, pbit);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    n_checks++;
    if ({data_out, valid, busy, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%b v=%b busy=%b ovr=%b perr=%b, want all 0",
               data_out, valid, busy, overrun, parity_err);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [W-1:0] bits;
    bits = 4'b1011;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_start: got busy=%b valid=%b, want busy=1 valid=0", busy, valid);
    end
    for (int i = 0; i < W; i++) begin
      bit last;
      last = (i == W - 1) && !PAR;
      tick(1'b0, bits[W-1-i], 1'b1, 1'b0, last, bits, 1'b1);
    end
    if (PAR) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, bits, 1'b1);
    n_checks++;
    if (data_out !== 4'b1011 || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_word: got data=%b v=%b busy=%b, want data=1011 v=1 busy=0",
               data_out, valid, busy);
    end
    idle(1'b1, 1'b0);
    n_checks++;
    if (valid !== 1'b0 || data_out !== 4'b1011) begin
      n_fail++;
      $display("FAIL basic_consume: got v=%b data=%b, want v=0 data=1011", valid, data_out);
    end
  endtask

  task automatic test_overrun();
    run_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (data_out !== 4'b0110 || valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first: got data=%b v=%b ovr=%b, want 0110 1 0", data_out, valid, overrun);
    end
    run_frame(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (data_out !== 4'b0110 || valid !== 1'b1 || overrun !== 1'b1 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drop: got data=%b v=%b ovr=%b perr=%b, want 0110 1 1 0",
               data_out, valid, overrun, parity_err);
    end
    idle(1'b0, 1'b1);
    n_checks++;
    if (overrun !== 1'b0 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_clear: got ovr=%b v=%b, want ovr=0 v=1", overrun, valid);
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_complete_with_handshake();
    run_frame(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_frame(4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (data_out !== 4'b1000 || valid !== 1'b1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_handshake: got data=%b v=%b ovr=%b, want 1000 1 0",
               data_out, valid, overrun);
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b0;
    idle(1'b0, 1'b0);
    reset = 1'b1;
    n_checks++;
    if ({data_out, valid, busy, overrun, parity_err} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got data=%b v=%b busy=%b ovr=%b perr=%b, want all 0",
               data_out, valid, busy, overrun, parity_err);
    end
    run_frame(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (data_out !== 4'b0101 || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_frame: got data=%b v=%b busy=%b, want 0101 1 0",
               data_out, valid, busy);
    end
    idle(1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_frame(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    n_checks++;
    if (data_out !== 4'b1100 || valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ign_word: got data=%b v=%b busy=%b, want 1100 1 0",
               data_out, valid, busy);
    end
    for (int i = 0; i < W + 2; i++) idle(1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || data_out !== 4'b1100) begin
      n_fail++;
      $display("FAIL start_ign_no_second: got busy=%b ovr=%b data=%b, want 0 0 1100",
               busy, overrun, data_out);
    end
    idle(1'b1, 1'b0);
  endtask

`ifdef SIPO_FRAME_CTRL_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] bits;
    bits = 4'b1011;
    for (int p = 1; p >= 0; p--) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < W; i++) tick(1'b0, bits[W-1-i], 1'b0, 1'b0, 1'b0, '0, 1'b0);
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_latency: got v=%b busy=%b after data bits, want v=0 busy=1",
                 valid, busy);
      end
      tick(1'b0, 1'(p), 1'b0, 1'b0, 1'b1, bits, 1'(p));
      n_checks++;
      if (valid !== 1'b1 || data_out !== 4'b1011 || parity_err !== 1'(p == 0) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_check pbit=%0d: got v=%b data=%b perr=%b busy=%b, want 1 1011 %0d 0",
                 p, valid, data_out, parity_err, busy, (p == 0));
      end
      idle(1'b1, 1'b0);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int gap;
      run_frame(W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0), W'($urandom));
      n_checks++;
      if (data_out !== m_data || valid !== m_valid || overrun !== m_ovr ||
          parity_err !== m_perr || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_frame %0d: got data=%b v=%b ovr=%b perr=%b busy=%b, want %b %b %b %b 0",
                 n, data_out, valid, overrun, parity_err, busy, m_data, m_valid, m_ovr, m_perr);
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        idle(1'($urandom), 1'($urandom_range(0, 3) == 0));
        n_checks++;
        if (data_out !== m_data || valid !== m_valid || overrun !== m_ovr ||
            parity_err !== m_perr || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_idle %0d: got data=%b v=%b ovr=%b perr=%b busy=%b, want %b %b %b %b 0",
                   n, data_out, valid, overrun, parity_err, busy, m_data, m_valid, m_ovr, m_perr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_complete_with_handshake();
    test_reset_mid_frame();
    test_start_ignored();
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
